// File: rtl/rect_pkg.sv
// Shared types and helpers for the rectangle overlay compositor.
// Slot field widths track the compositor's default geometry.
package rect_pkg;

    localparam int SLOT_XW = 10;
    localparam int SLOT_YW = 10;
    localparam int SLOT_CW = 2;
    localparam int IDX_W = 4;
    localparam int SPAN_W = 16;

    typedef struct packed {
        logic                   enable;
        logic [SLOT_XW-1:0]     x0;
        logic [SLOT_XW-1:0]     x1;
        logic [SLOT_YW-1:0]     y0;
        logic [SLOT_YW-1:0]     y1;
        logic [3*SLOT_CW-1:0]   color;
    } slot_t;

    typedef struct packed {
        logic [SPAN_W-1:0] lo;
        logic [SPAN_W-1:0] hi;
    } span_t;

    function automatic span_t min_max(
        input logic [SPAN_W-1:0] a,
        input logic [SPAN_W-1:0] b
    );
        span_t s;
        s.lo = (a < b) ? a : b;
        s.hi = (a < b) ? b : a;
        return s;
    endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational hit test of one rectangle slot against one pixel.
// Edges are exclusive, so a span of width 0 or 1 never hits.
module rect_hit
    import rect_pkg::*;
#(
    parameter int XW = SLOT_XW,
    parameter int YW = SLOT_YW
) (
    input  logic          enable,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [XW-1:0] pixel,
    input  logic [YW-1:0] line,
    output logic          hit
);

    span_t xs;
    span_t ys;
    logic [SPAN_W-1:0] px;
    logic [SPAN_W-1:0] ln;

    assign xs = min_max(SPAN_W'(x0), SPAN_W'(x1));
    assign ys = min_max(SPAN_W'(y0), SPAN_W'(y1));
    assign px = SPAN_W'(pixel);
    assign ln = SPAN_W'(line);

    assign hit = enable
               && (px > xs.lo) && (px < xs.hi)
               && (ln > ys.lo) && (ln < ys.hi);

endmodule

// File: rtl/rect_compositor.sv
// Multi-rectangle overlay renderer with frame-synchronous config commit
// and a two-stage registered colour pipeline.
module rect_compositor
    import rect_pkg::*;
#(
    parameter int NUM_RECTS = 4,
    parameter int XW = SLOT_XW,
    parameter int YW = SLOT_YW,
    parameter int CW = SLOT_CW,
    parameter logic [3*CW-1:0] BG_COLOR = {3*CW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] pixel_in,
    input  logic [YW-1:0] line_in,
    input  logic          visible_in,
    input  logic          frame_start,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [3:0]    cfg_idx,
    input  logic          cfg_enable,
    input  logic [XW-1:0] cfg_x0,
    input  logic [XW-1:0] cfg_x1,
    input  logic [YW-1:0] cfg_y0,
    input  logic [YW-1:0] cfg_y1,
    input  logic [3*CW-1:0] cfg_color,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue,
    output logic          visible_out,
    output logic          commit_pulse
);

    slot_t shadow [NUM_RECTS];
    slot_t active [NUM_RECTS];
    slot_t wr_slot;

    logic [NUM_RECTS-1:0] hits;
    logic [NUM_RECTS-1:0] hit_q;
    logic                 vis_q;
    logic [3*CW-1:0]      pick;
    logic [3*CW-1:0]      col_q;

    assign cfg_ready = rst_n & ~frame_start;

    assign wr_slot = '{
        enable: cfg_enable,
        x0:     cfg_x0,
        x1:     cfg_x1,
        y0:     cfg_y0,
        y1:     cfg_y1,
        color:  cfg_color
    };

    // Out-of-range indices match no slot, so such writes vanish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= frame_start;
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (frame_start)
                    active[i] <= shadow[i];
                if (cfg_valid && cfg_ready && cfg_idx == IDX_W'(i))
                    shadow[i] <= wr_slot;
            end
        end
    end

    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        rect_hit #(
            .XW(XW),
            .YW(YW)
        ) u_hit (
            .enable(active[g].enable),
            .x0    (active[g].x0),
            .x1    (active[g].x1),
            .y0    (active[g].y0),
            .y1    (active[g].y1),
            .pixel (pixel_in),
            .line  (line_in),
            .hit   (hits[g])
        );
    end

    // Walk downward so the lowest-index hit wins.
    always_comb begin
        pick = BG_COLOR;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (hit_q[i])
                pick = active[i].color;
        end
        if (!vis_q)
            pick = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q       <= '0;
            vis_q       <= 1'b0;
            col_q       <= '0;
            visible_out <= 1'b0;
        end else begin
            hit_q       <= hits;
            vis_q       <= visible_in;
            col_q       <= pick;
            visible_out <= vis_q;
        end
    end

    assign red   = col_q[3*CW-1:2*CW];
    assign green = col_q[2*CW-1:CW];
    assign blue  = col_q[CW-1:0];

endmodule

// File: tb/tb_rect_compositor.sv
// Self-checking bench for rect_compositor: directed tables, corner
// sequences and random traffic against a slot-list reference model.
module tb_rect_compositor;

    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pixel_in = '0;
    logic [9:0] line_in = '0;
    logic       visible_in = 1'b0;
    logic       frame_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_idx = '0;
    logic       cfg_enable = 1'b0;
    logic [9:0] cfg_x0 = '0;
    logic [9:0] cfg_x1 = '0;
    logic [9:0] cfg_y0 = '0;
    logic [9:0] cfg_y1 = '0;
    logic [5:0] cfg_color = '0;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic       visible_out;
    logic       commit_pulse;

    rect_compositor #(.NUM_RECTS(NR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_in    (pixel_in),
        .line_in     (line_in),
        .visible_in  (visible_in),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idx     (cfg_idx),
        .cfg_enable  (cfg_enable),
        .cfg_x0      (cfg_x0),
        .cfg_x1      (cfg_x1),
        .cfg_y0      (cfg_y0),
        .cfg_y1      (cfg_y1),
        .cfg_color   (cfg_color),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .visible_out (visible_out),
        .commit_pulse(commit_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        int       x0, x1, y0, y1;
        bit [5:0] col;
    } mslot_t;

    typedef struct {
        bit [5:0] col;
        bit       vis;
    } exp_t;

    typedef struct {
        int       px;
        int       ln;
        bit       vis;
        bit [5:0] col;
    } vec_t;

    mslot_t m_sh [NR];
    mslot_t m_act [NR];
    exp_t   exq [$];
    int     vectors = 0;
    int     miscompares = 0;

    localparam bit [5:0] BG  = 6'b111111;
    localparam bit [5:0] RED = 6'b110000;
    localparam bit [5:0] GRN = 6'b001100;
    localparam bit [5:0] BLU = 6'b000011;
    localparam bit [5:0] CYN = 6'b001111;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic bit [5:0] ref_color(int px, int ln, bit vis);
        if (!vis) return 6'd0;
        for (int i = 0; i < NR; i++) begin
            int xl, xh, yl, yh;
            xl = (m_act[i].x0 < m_act[i].x1) ? m_act[i].x0 : m_act[i].x1;
            xh = (m_act[i].x0 < m_act[i].x1) ? m_act[i].x1 : m_act[i].x0;
            yl = (m_act[i].y0 < m_act[i].y1) ? m_act[i].y0 : m_act[i].y1;
            yh = (m_act[i].y0 < m_act[i].y1) ? m_act[i].y1 : m_act[i].y0;
            if (m_act[i].en && px > xl && px < xh && ln > yl && ln < yh)
                return m_act[i].col;
        end
        return BG;
    endfunction

    task automatic set_cfg(int idx, bit en, int x0, int x1,
                           int y0, int y1, bit [5:0] col);
        cfg_idx    = 4'(idx);
        cfg_enable = en;
        cfg_x0     = 10'(x0);
        cfg_x1     = 10'(x1);
        cfg_y0     = 10'(y0);
        cfg_y1     = 10'(y1);
        cfg_color  = col;
    endtask

    // One clock: drive, check handshake, advance, update model, score.
    task automatic cycle(int px, int ln, bit vis, bit fs, bit cv,
                         bit force_e, bit [5:0] fe);
        exp_t e;
        bit   rst;
        pixel_in    = 10'(px);
        line_in     = 10'(ln);
        visible_in  = vis;
        frame_start = fs;
        cfg_valid   = cv;
        rst         = rst_n;
        #1;
        chk("cfg_ready", int'(cfg_ready), int'(rst & ~fs));
        e.col = force_e ? fe : ref_color(px, ln, vis);
        e.vis = vis;
        @(posedge clk);
        if (!rst) begin
            foreach (m_sh[i]) m_sh[i] = '{default: 0};
            foreach (m_act[i]) m_act[i] = '{default: 0};
        end else if (fs) begin
            foreach (m_act[i]) m_act[i] = m_sh[i];
        end else if (cv && cfg_idx < NR) begin
            m_sh[cfg_idx] = '{cfg_enable, int'(cfg_x0), int'(cfg_x1),
                              int'(cfg_y0), int'(cfg_y1), cfg_color};
        end
        #1;
        chk("commit_pulse", int'(commit_pulse), int'(rst & fs));
        if (!rst) begin
            exq.delete();
            exq.push_back('{6'd0, 1'b0});
            chk("reset_rgb", int'({red, green, blue}), 0);
            chk("reset_vis", int'(visible_out), 0);
        end else begin
            exq.push_back(e);
            if (exq.size() >= 2) begin
                exp_t h;
                h = exq.pop_front();
                chk("rgb", int'({red, green, blue}), int'(h.col));
                chk("visible_out", int'(visible_out), int'(h.vis));
            end
        end
    endtask

    task automatic pix(int px, int ln, bit vis);
        cycle(px, ln, vis, 1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic pix_exp(int px, int ln, bit [5:0] col);
        cycle(px, ln, 1'b1, 1'b0, 1'b0, 1'b1, col);
    endtask

    task automatic frame();
        cycle(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic write();
        cycle(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    endtask

    task automatic flush();
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{51, 21, 1'b1, RED};
        tbl[1] = '{50, 21, 1'b1, BG};
        tbl[2] = '{100, 21, 1'b1, BG};
        tbl[3] = '{99, 79, 1'b1, RED};
        tbl[4] = '{75, 80, 1'b1, BG};
        tbl[5] = '{75, 20, 1'b1, BG};
        tbl[6] = '{75, 50, 1'b0, 6'd0};
        tbl[7] = '{0, 0, 1'b1, BG};
        tbl[8] = '{75, 50, 1'b1, RED};
        tbl[9] = '{101, 50, 1'b1, BG};

        foreach (m_sh[i]) m_sh[i] = '{default: 0};
        foreach (m_act[i]) m_act[i] = '{default: 0};

        // Reset, then an unconfigured frame: visible is BG, blanking 0.
        repeat (3) pix(5, 5, 1'b1);
        rst_n = 1'b1;
        frame();
        for (int i = 0; i < 12; i++) begin
            cycle(i * 7, i * 3, i[0], 1'b0, 1'b0, 1'b1,
                  i[0] ? BG : 6'd0);
        end
        flush();

        // Slot 0 with swapped x edges, then the boundary table.
        set_cfg(0, 1, 100, 50, 20, 80, RED);
        write();
        frame();
        foreach (tbl[i])
            cycle(tbl[i].px, tbl[i].ln, tbl[i].vis, 1'b0, 1'b0,
                  1'b1, tbl[i].col);
        flush();

        // Isolated pixel: exactly two clocks of latency.
        pix(51, 21, 1'b1);
        #0;
        chk("latency_1clk", int'(visible_out), 0);
        pix(0, 0, 1'b0);
        chk("latency_2clk", int'({red, green, blue}), int'(RED));
        pix(0, 0, 1'b0);

        // Overlap priority, then disabling the winner.
        set_cfg(1, 1, 60, 120, 10, 40, BLU);
        write();
        frame();
        pix_exp(70, 25, RED);
        pix_exp(110, 15, BLU);
        flush();
        set_cfg(0, 0, 100, 50, 20, 80, RED);
        write();
        frame();
        pix_exp(70, 25, BLU);
        flush();

        // Mid-frame write stays invisible until the next commit.
        pix_exp(10, 10, BG);
        set_cfg(2, 1, 5, 15, 15, 5, GRN);
        cycle(10, 10, 1'b1, 1'b0, 1'b1, 1'b1, BG);
        pix_exp(10, 10, BG);
        pix_exp(11, 11, BG);
        flush();
        // cfg_valid held across frame_start: accepted a cycle later.
        set_cfg(3, 1, 200, 300, 200, 300, CYN);
        cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        write();
        pix_exp(10, 10, GRN);
        pix_exp(250, 250, BG);
        flush();
        frame();
        pix_exp(250, 250, CYN);
        flush();

        // Degenerate spans and an out-of-range slot index.
        set_cfg(0, 1, 60, 60, 0, 100, RED);
        write();
        set_cfg(1, 1, 60, 61, 0, 100, RED);
        write();
        set_cfg(15, 1, 0, 1000, 0, 1000, RED);
        write();
        frame();
        pix_exp(60, 50, BG);
        pix_exp(61, 50, BG);
        pix_exp(30, 50, BG);
        pix_exp(10, 10, GRN);
        flush();

        // Mid-frame reset wipes all slots.
        pix_exp(10, 10, GRN);
        pix_exp(250, 250, CYN);
        rst_n = 1'b0;
        pix(10, 10, 1'b1);
        rst_n = 1'b1;
        pix_exp(10, 10, BG);
        pix_exp(250, 250, BG);
        flush();
        frame();
        pix_exp(10, 10, BG);
        flush();

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 63) begin
                frame();
            end else if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                pix(0, 0, 1'b0);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                int idx, x0, y0;
                idx = $urandom_range(0, 5);
                if (idx == 5) idx = 15;
                x0 = $urandom_range(0, 127);
                y0 = $urandom_range(0, 127);
                set_cfg(idx, 1'($urandom_range(0, 3) != 0),
                        x0,
                        $urandom_range(0, 1) ? x0 + $urandom_range(0, 2)
                                             : $urandom_range(0, 127),
                        y0, $urandom_range(0, 127),
                        6'($urandom));
                cycle($urandom_range(0, 127), $urandom_range(0, 127),
                      1'($urandom_range(0, 4) != 0), 1'b0, 1'b1,
                      1'b0, 6'd0);
            end else begin
                pix($urandom_range(0, 127), $urandom_range(0, 127),
                    1'($urandom_range(0, 4) != 0));
            end
        end
        flush();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rect_compositor.md
Name: rect_compositor

Overview:
Parametrised multi-rectangle overlay renderer for the VGA output path. It replaces the fixed two-rectangle combinational painter and sits between the sync/counter generator and the DAC pins. NUM_RECTS rectangles are each given runtime-programmable corners and colour through a valid/ready config port. Programmed values are double-buffered and committed only at frame start, so a frame never tears. Output colour is a registered two-stage pipeline.

Parameters:
NUM_RECTS, 4, number of rectangle slots (1..16)
XW, 10, pixel counter width
YW, 10, line counter width
CW, 2, bits per colour channel
BG_COLOR, {3*CW{1'b1}} (white), background colour {r,g,b} used for visible pixels outside every enabled rectangle

Ports:
clk  in  1  system pixel clock
rst_n  in  1  synchronous active-low reset
pixel_in  in  XW  current pixel counter
line_in  in  YW  current line counter
visible_in  in  1  high during active video
frame_start  in  1  one-cycle pulse at the first cycle of a frame
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid and cfg_ready are both high
cfg_idx  in  4  target slot
cfg_enable  in  1  slot enable
cfg_x0, cfg_x1  in  XW  horizontal edges, in either order
cfg_y0, cfg_y1  in  YW  vertical edges, in either order
cfg_color  in  3*CW  slot colour {r,g,b}
red, green, blue  out  CW each  registered colour output
visible_out  out  1  visible_in delayed to align with the colour outputs
commit_pulse  out  1  one cycle high when shadow registers are copied to active

Behaviour:
- Reset (rst_n low at a clk edge) clears the following to 0: all shadow and active slots (enable, edges, colour), both pipeline stages, red/green/blue, visible_out and commit_pulse. Outputs hold 0 while rst_n is low. A reset in mid-frame aborts the frame; rendering resumes on the next visible pixel, with every slot disabled.
- cfg_ready = rst_n & ~frame_start. A write into a slot on the same edge as a commit is therefore impossible.
- Accepted write: the shadow slot cfg_idx takes {enable, x0, x1, y0, y1, color} on that edge. If cfg_idx >= NUM_RECTS, the write is accepted and discarded. Repeated writes to a slot before a commit: the last write wins.
- Commit: on an edge with frame_start high, every active slot is loaded from its shadow slot, and commit_pulse is high in the following cycle. A commit happens on every frame_start, even with no pending writes. The active set is constant between commits.
- Hit test for slot i: enabled, and min(x0,x1) < pixel_in < max(x0,x1), and min(y0,y1) < line_in < max(y0,y1).
  - Comparisons are strict and unsigned.
  - If x0==x1, or |x0-x1|==1, the slot never hits; the same applies to y.
- Stage 1 (edge n): register the NUM_RECTS-bit hit vector and visible_in, computed from the inputs at edge n.
- Stage 2 (edge n+1): priority-select the lowest-index set hit bit. The colour is that slot's active colour; with no hit it is BG_COLOR. If the stage-1 visible bit is 0, the colour is 0. Register the colour and visible_out.
- Latency: exactly 2 clk from pixel_in/line_in/visible_in to red/green/blue/visible_out. Throughput: one pixel per clk, no stalls.
- Stage 2 uses the colour from the active registers at the time of stage 2. A commit therefore affects pixels in flight by at most 2 cycles; these fall in blanking by construction.
- Colour split: red = color[3*CW-1:2*CW], green = color[2*CW-1:CW], blue = color[CW-1:0].

Decomposition:
- Package rect_pkg holds the slot struct typedef {enable, x0, x1, y0, y1, color}, the slot-index width constant, and a function that returns the minimum and maximum of two values.
- One sub-module, rect_hit, is natural: a combinational test of one slot against one pixel/line. It is instantiated NUM_RECTS times by a generate loop.
- Config storage, commit logic, priority encoder and pipeline live in the top module.

Test Plan:
- Reset then a full frame with no config writes: all visible pixels give BG (3,3,3); blanking gives (0,0,0); commit_pulse is high once per frame_start.
- Slot 0 set to x0=100, x1=50, y0=20, y1=80, color red (3,0,0), then commit. Pixel (51,21) is red; pixels (50,21) and (100,21) are BG; the output appears exactly 2 clk after the input.
- Slot 0 red and slot 1 blue (0,0,3), overlapping. The overlap region shows red. After slot 0 is disabled and committed, it shows blue.
- Slot 2 written mid-frame: the current frame is unchanged. The change appears only after the next frame_start. With cfg_valid held during frame_start, cfg_ready is 0 and the write completes on the following cycle.
- Degenerate and invalid writes: x0=x1=60 never hits; x0=60, x1=61 never hits; cfg_idx=15 with NUM_RECTS=4 is accepted and causes no visible change.
- rst_n pulled low mid-frame: outputs go to 0 on the next edge. After release, the image is all BG until new config is written and committed.
